// File: rtl/oe_ctrl_if.sv
// Switch, fault and output-enable bundle for the analog OE controller.
interface oe_ctrl_if #(
    parameter int CH = 2
);
    logic [CH-1:0] sw;
    logic          fault;
    logic [CH-1:0] oe;
    logic [CH-1:0] sw_db;
    logic [CH-1:0] armed;
    logic [CH-1:0] locked;

    modport master (
        output sw,
        output fault,
        input  oe,
        input  sw_db,
        input  armed,
        input  locked
    );

    modport slave (
        input  sw,
        input  fault,
        output oe,
        output sw_db,
        output armed,
        output locked
    );
endinterface

// File: rtl/oe_ctrl.sv
// Per-channel OE controller: sync, debounce, settle delay, latched fault off.
module oe_ctrl #(
    parameter int CH            = 2,
    parameter int DEBOUNCE_CYC  = 1000,
    parameter int SETTLE_CYC    = 16,
    parameter bit OE_ACTIVE_LOW = 1'b0
) (
    input logic       clk,
    input logic       rst,
    oe_ctrl_if.slave  bus
);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYC);
    localparam logic [SW-1:0] SET_LAST =
        SW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

    typedef enum logic [1:0] {
        S_OFF,
        S_ARM,
        S_ON
    } state_t;

    logic [CH-1:0] oe_v;
    logic [CH-1:0] db_v;
    logic [CH-1:0] arm_v;
    logic [CH-1:0] lk_v;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic          s1;
        logic          s2;
        logic          db;
        logic [DW-1:0] dcnt;
        state_t        st;
        state_t        st_nx;
        logic [SW-1:0] scnt;
        logic [SW-1:0] scnt_nx;
        logic          lk;
        logic          lk_nx;
        logic          oe_q;
        logic          arm_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                s1 <= 1'b0;
                s2 <= 1'b0;
            end else begin
                s1 <= bus.sw[i];
                s2 <= s1;
            end
        end

        // Counter holds the run length; the flip happens one edge after it
        // has counted a full DEBOUNCE_CYC run, so it must be able to hold it.
        always_ff @(posedge clk) begin
            if (rst) begin
                dcnt <= '0;
                db   <= 1'b0;
            end else if (s2 == db) begin
                dcnt <= '0;
            end else if (dcnt == DB_MAX) begin
                db   <= s2;
                dcnt <= '0;
            end else begin
                dcnt <= dcnt + DW'(1);
            end
        end

        always_comb begin
            st_nx   = st;
            scnt_nx = scnt;
            // Fault latches only while pressed; any debounced release clears.
            lk_nx   = db & (lk | bus.fault);
            unique case (st)
                S_OFF: begin
                    if (db && !bus.fault && !lk) begin
                        st_nx   = (SETTLE_CYC == 0) ? S_ON : S_ARM;
                        scnt_nx = '0;
                    end
                end
                S_ARM: begin
                    if (bus.fault || !db) begin
                        st_nx = S_OFF;
                    end else if (scnt == SET_LAST) begin
                        st_nx = S_ON;
                    end else begin
                        scnt_nx = scnt + SW'(1);
                    end
                end
                S_ON: begin
                    if (bus.fault || !db) begin
                        st_nx = S_OFF;
                    end
                end
                default: st_nx = S_OFF;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                st    <= S_OFF;
                scnt  <= '0;
                lk    <= 1'b0;
                oe_q  <= OE_ACTIVE_LOW;
                arm_q <= 1'b0;
            end else begin
                st    <= st_nx;
                scnt  <= scnt_nx;
                lk    <= lk_nx;
                oe_q  <= (st_nx == S_ON) ^ OE_ACTIVE_LOW;
                arm_q <= (st_nx == S_ARM);
            end
        end

        assign oe_v[i]  = oe_q;
        assign db_v[i]  = db;
        assign arm_v[i] = arm_q;
        assign lk_v[i]  = lk;
    end

    assign bus.oe     = oe_v;
    assign bus.sw_db  = db_v;
    assign bus.armed  = arm_v;
    assign bus.locked = lk_v;
endmodule

// File: tb/tb_oe_ctrl.sv
// Bench for oe_ctrl: three builds driven by one stimulus stream,
// checked every cycle against a window/phase model.
module tb_oe_ctrl;
    localparam int CH = 2;
    localparam int D  = 4;
    localparam int SC [3]  = '{3, 0, 12};
    localparam bit POL [3] = '{1'b0, 1'b1, 1'b0};
    localparam int P_OFF = 0;
    localparam int P_ARM = 1;
    localparam int P_ON  = 2;
    localparam int K_OE  = 0;
    localparam int K_DB  = 1;
    localparam int K_ARM = 2;
    localparam int K_LK  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] sw  = '0;
    logic          fault = 1'b0;

    int tests = 0;
    int fails = 0;
    int ecnt  = 0;
    int base  = 0;

    bit            hist [3][CH][D+2];
    bit            mdb  [3][CH];
    bit            mlk  [3][CH];
    int            ph   [3][CH];
    int            age  [3][CH];
    logic [CH-1:0] acc_oe  [3];
    logic [CH-1:0] acc_arm [3];

    oe_ctrl_if #(.CH(CH)) ifa ();
    oe_ctrl_if #(.CH(CH)) ifb ();
    oe_ctrl_if #(.CH(CH)) ifc ();

    assign ifa.sw = sw;
    assign ifb.sw = sw;
    assign ifc.sw = sw;
    assign ifa.fault = fault;
    assign ifb.fault = fault;
    assign ifc.fault = fault;

    oe_ctrl #(.CH(CH), .DEBOUNCE_CYC(D), .SETTLE_CYC(3),
              .OE_ACTIVE_LOW(1'b0)) u_a (.clk(clk), .rst(rst), .bus(ifa));
    oe_ctrl #(.CH(CH), .DEBOUNCE_CYC(D), .SETTLE_CYC(0),
              .OE_ACTIVE_LOW(1'b1)) u_b (.clk(clk), .rst(rst), .bus(ifb));
    oe_ctrl #(.CH(CH), .DEBOUNCE_CYC(D), .SETTLE_CYC(12),
              .OE_ACTIVE_LOW(1'b0)) u_c (.clk(clk), .rst(rst), .bus(ifc));

    always #5 clk = ~clk;

    function automatic logic [CH-1:0] dut_out(int c, int k);
        logic [CH-1:0] o [4];
        case (c)
            0: o = '{ifa.oe, ifa.sw_db, ifa.armed, ifa.locked};
            1: o = '{ifb.oe, ifb.sw_db, ifb.armed, ifb.locked};
            default: o = '{ifc.oe, ifc.sw_db, ifc.armed, ifc.locked};
        endcase
        return o[k];
    endfunction

    function automatic logic [CH-1:0] exp_out(int c, int k);
        logic [CH-1:0] v;
        v = '0;
        for (int i = 0; i < CH; i++) begin
            case (k)
                K_OE:    v[i] = (ph[c][i] == P_ON) ^ POL[c];
                K_DB:    v[i] = mdb[c][i];
                K_ARM:   v[i] = (ph[c][i] == P_ARM);
                default: v[i] = mlk[c][i];
            endcase
        end
        return v;
    endfunction

    // A level is accepted once the synchronised samples have disagreed
    // with the current level for D+1 consecutive edges.
    task automatic model_edge();
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < CH; i++) begin
                bit od;
                bit flip;
                if (rst) begin
                    for (int j = 0; j < D + 2; j++) hist[c][i][j] = 1'b0;
                    mdb[c][i] = 1'b0;
                    mlk[c][i] = 1'b0;
                    ph[c][i]  = P_OFF;
                    age[c][i] = 0;
                end else begin
                    od   = mdb[c][i];
                    flip = 1'b1;
                    for (int j = 1; j <= D + 1; j++)
                        if (hist[c][i][j] == od) flip = 1'b0;
                    if (ph[c][i] != P_OFF && (fault || !od)) begin
                        ph[c][i] = P_OFF;
                    end else if (ph[c][i] == P_ARM) begin
                        if (age[c][i] == SC[c] - 1) ph[c][i] = P_ON;
                        else age[c][i]++;
                    end else if (ph[c][i] == P_OFF && od && !fault
                                 && !mlk[c][i]) begin
                        ph[c][i]  = (SC[c] == 0) ? P_ON : P_ARM;
                        age[c][i] = 0;
                    end
                    mlk[c][i] = od && (mlk[c][i] || fault);
                    mdb[c][i] = flip ? !od : od;
                    for (int j = D + 1; j > 0; j--)
                        hist[c][i][j] = hist[c][i][j-1];
                    hist[c][i][0] = sw[i];
                end
            end
        end
    endtask

    task automatic chk(input string nm, input logic [CH-1:0] act,
                       input logic [CH-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b want %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        ecnt++;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("c%0d_oe", c), dut_out(c, K_OE), exp_out(c, K_OE));
            chk($sformatf("c%0d_db", c), dut_out(c, K_DB), exp_out(c, K_DB));
            chk($sformatf("c%0d_arm", c), dut_out(c, K_ARM), exp_out(c, K_ARM));
            chk($sformatf("c%0d_lk", c), dut_out(c, K_LK), exp_out(c, K_LK));
            acc_oe[c]  |= dut_out(c, K_OE) ^ {CH{POL[c]}};
            acc_arm[c] |= dut_out(c, K_ARM);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Edge index (from base) at which an output first reaches target.
    task automatic meas(input int c, input int k, input logic [CH-1:0] tgt,
                        input int want, input string nm);
        int hit;
        hit = -1;
        while (hit < 0 && ecnt - base < 40) begin
            tick();
            if (dut_out(c, k) === tgt) hit = ecnt - base - 1;
        end
        chk_i(nm, hit, want);
    endtask

    initial begin
        int g;
        for (int c = 0; c < 3; c++) begin
            acc_oe[c]  = '0;
            acc_arm[c] = '0;
        end

        // reset held with switches pressed
        sw = 2'b11;
        ticks(1);
        chk("rst_oe_a", ifa.oe, 2'b00);
        chk("rst_oe_b", ifb.oe, 2'b11);
        ticks(2);
        chk("rst_db", ifa.sw_db, 2'b00);
        rst  = 1'b0;
        base = ecnt;
        meas(0, K_DB, 2'b11, 6, "t1_db_rise");
        meas(1, K_OE, 2'b00, 7, "t6_oe_low");
        meas(0, K_OE, 2'b11, 10, "t1_oe_rise");

        // glitch rejection on ch0
        sw = 2'b10;
        ticks(12);
        sw = 2'b11;
        ticks(3);
        sw = 2'b10;
        g = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            g |= int'(ifa.sw_db[0] | ifa.oe[0]);
        end
        chk_i("t2_glitch", g, 0);
        sw   = 2'b11;
        base = ecnt;
        meas(0, K_DB, 2'b11, 6, "t2_db_rise");
        meas(0, K_OE, 2'b11, 10, "t2_oe_rise");

        // arm abort on the long-settle build, ch1
        sw = 2'b01;
        ticks(14);
        sw   = 2'b11;
        base = ecnt;
        ticks(8);
        chk("t3_armed", ifc.armed & 2'b10, 2'b10);
        sw = 2'b01;
        acc_oe[2] = '0;
        meas(2, K_ARM, 2'b00, 15, "t3_arm_drop");
        ticks(10);
        chk("t3_no_oe", acc_oe[2] & 2'b10, 2'b00);

        // fault lock
        sw = 2'b11;
        ticks(25);
        chk("t4_on", ifa.oe, 2'b11);
        fault = 1'b1;
        tick();
        fault = 1'b0;
        chk("t4_oe_off", ifa.oe, 2'b00);
        chk("t4_locked", ifa.locked, 2'b11);
        acc_oe[0] = '0;
        ticks(20);
        chk("t4_stay_off", acc_oe[0], 2'b00);
        sw = 2'b00;
        ticks(10);
        chk("t4_unlock", ifa.locked, 2'b00);
        sw   = 2'b11;
        base = ecnt;
        meas(0, K_OE, 2'b11, 10, "t4_reenable");

        // reset mid-operation: ch0 arming, ch1 on
        sw = 2'b10;
        ticks(12);
        sw   = 2'b11;
        base = ecnt;
        meas(0, K_ARM, 2'b01, 7, "t5_arm_in");
        chk("t5_ch1_on", ifa.oe, 2'b10);
        rst = 1'b1;
        tick();
        chk("t5_rst_oe", ifa.oe, 2'b00);
        chk("t5_rst_arm", ifa.armed, 2'b00);
        chk("t5_rst_db", ifa.sw_db, 2'b00);
        chk("t5_rst_oe_b", ifb.oe, 2'b11);
        rst  = 1'b0;
        base = ecnt;
        meas(0, K_OE, 2'b11, 10, "t5_restart");

        chk("t6_never_armed", acc_arm[1], 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
